div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage, beside the ALU.
- Takes the same rs/rt operand pair the ALU consumes and implements DIV/DIVU for the HI/LO path.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Uses a start/ready handshake and raises a stall request so the hazard unit freezes IF/ID/EX while it runs.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- a  input  DATA_W  dividend (rs)
- b  input  DATA_W  divisor (rt)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- start  input  1  request a division; sampled only in IDLE
- annul  input  1  cancel the in-flight or requested division (exception/flush)
- stall_req  output  1  combinational; high while a division is pending or running
- ready  output  1  one-cycle pulse; result is valid
- result  output  2*DATA_W  {remainder → HI, quotient → LO}

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, ready=0, result=0, internal dividend/divisor/partial remainder=0. rst overrides everything, including mid-operation.
- States are IDLE, ON, DONE; encodings come from the shared defines.
- IDLE:
  - start=1 and annul=0 and b!=0: latch |a|, |b| and the sign flags, clear the partial remainder, counter=0, go to ON.
  - start=1 and annul=0 and b==0: load result={a, all-ones}, go to DONE.
  - Otherwise stay in IDLE.
- ON:
  - Each cycle: shift {rem, dividend} left by 1 and trial-subtract the divisor from the upper part.
  - Nonnegative trial: keep the difference and set quotient bit 1. Negative trial: restore and set quotient bit 0.
  - counter increments. The iteration at counter=DATA_W-1 is the last; go to DONE.
  - annul=1: go to IDLE; no ready and result unchanged.
- DONE:
  - Apply the sign fix-up and write result; ready=1 for exactly this cycle; go to IDLE.
  - annul=1 in DONE suppresses ready and the result write.
- Latency: start accepted at edge N → ready high during the cycle after edge N+32 (33 cycles). Divide-by-zero → ready in the cycle after edge N (1 cycle).
- stall_req = (state==IDLE & start & ~annul) | (state==ON). It is low in DONE, so the pipeline resumes in the same cycle the result is presented.
- start while in ON or DONE is ignored; operands are captured only in IDLE. start and annul together in IDLE: annul wins, nothing starts.
- Signed rules:
  - quotient = -(|a|/|b|) when sign(a)!=sign(b).
  - remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (no trap).
- Unsigned: operands are used as-is, no fix-up.
- result holds its value until the next DONE write or reset, so HI/LO may be written after stall release.
- Width: the partial remainder is DATA_W+1 bits so the trial subtraction borrow is explicit. Absolute value of 0x80000000 is 0x80000000 treated as unsigned.

Decomposition:
- defines.vh gets:
  - state encodings DIV_IDLE, DIV_ON, DIV_DONE (2-bit)
  - DIV_CONTROL/DIVU_CONTROL alucontrol codes, next to the existing ALU control codes
  - DIV_ZERO_QUOT (all-ones)
- No sub-module. Abs/negate is a small function inside the module; the datapath is one always block plus the FSM.

Test Plan:
- Unsigned 100 / 7: start at edge N → stall_req high for cycles N..N+32, ready exactly in cycle after edge N+32, result={32'd2, 32'd14}.
- Signed -7 / 2 (0xFFFFFFF9 / 2): result={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2: result={0x00000001, 0xFFFFFFFD}.
- Divide by zero, a=5, b=0, either signedness: ready one cycle after start, result={0x00000005, 0xFFFFFFFF}, never enters ON.
- Signed 0x80000000 / 0xFFFFFFFF → result={0, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- annul after 10 ON cycles → state IDLE next cycle, no ready, result unchanged. A following start 40/3 completes normally with {1, 13}.
- Interference checks:
  - start toggled and operands changed while in ON → the original result is unaffected.
  - rst at iteration 20 → all outputs 0 next cycle.
  - start+annul in IDLE → nothing starts.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: divider FSM encodings, ALU control codes and divide-by-zero quotient.
package div_unit_pkg;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ON   = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;
   localparam logic [3:0]  DIV_CONTROL   = 4'b1010;
   localparam logic [3:0]  DIVU_CONTROL  = 4'b1011;
   localparam logic [31:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: operand/handshake bundle between EX stage (master) and the divider (slave).
interface div_unit_if #(parameter int DATA_W = 32);
   logic [DATA_W-1:0]   a;
   logic [DATA_W-1:0]   b;
   logic                signed_div;
   logic                start;
   logic                annul;
   logic                stall_req;
   logic                ready;
   logic [2*DATA_W-1:0] result;
   modport master (output a, b, signed_div, start, annul, input stall_req, ready, result);
   modport slave  (input a, b, signed_div, start, annul, output stall_req, ready, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU, one quotient bit per cycle, result {HI=rem, LO=quot}.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus_io
);
   localparam int CW = $clog2(DATA_W);
   div_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, quot, remv;
   logic                negq_q, negq_d, negr_q, negr_d;
   logic [2*DATA_W-1:0] res_q, res_d, fixed;
   logic [DATA_W:0]     shl, trial;
   logic                zero, sa, sb;
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
      return (s && x[DATA_W-1]) ? -x : x;
   endfunction
   // One extra bit on the shifted remainder makes the trial borrow explicit.
   assign shl   = {rem_q, dvd_q[DATA_W-1]};
   assign trial = shl - {1'b0, dvs_q};
   assign quot  = negq_q ? -dvd_q : dvd_q;
   assign remv  = negr_q ? -rem_q : rem_q;
   assign fixed = {remv, quot};
   assign zero  = bus_io.b == '0;
   assign sa    = bus_io.signed_div && bus_io.a[DATA_W-1];
   assign sb    = bus_io.signed_div && bus_io.b[DATA_W-1];
   assign bus_io.ready     = state_q == DIV_DONE && !bus_io.annul;
   assign bus_io.result    = bus_io.ready ? fixed : res_q;
   assign bus_io.stall_req = (state_q == DIV_IDLE && bus_io.start && !bus_io.annul) || state_q == DIV_ON;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;
      case (state_q)
         DIV_IDLE: if (bus_io.start && !bus_io.annul) begin
            // Divide-by-zero bypasses ON with fix-up disabled so DONE emits {a, all-ones}.
            rem_d   = zero ? bus_io.a : '0;
            dvd_d   = zero ? '1 : mag(bus_io.a, bus_io.signed_div);
            dvs_d   = mag(bus_io.b, bus_io.signed_div);
            negq_d  = !zero && (sa ^ sb);
            negr_d  = !zero && sa;
            cnt_d   = '0;
            state_d = zero ? DIV_DONE : DIV_ON;
         end
         DIV_ON: if (bus_io.annul) begin
            state_d = DIV_IDLE;
         end else begin
            rem_d   = trial[DATA_W] ? shl[DATA_W-1:0] : trial[DATA_W-1:0];
            dvd_d   = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(DATA_W - 1) ? DIV_DONE : DIV_ON;
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
            res_d   = bus_io.annul ? res_q : fixed;
         end
         default: state_d = DIV_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
      end
   end
endmodule
